output_unit: RTL and testbench
==============================

# output_unit

Router output port transmitter, one per direction. Collects one packet of flits from the switch stage into a local buffer (store-and-forward), then requests the downstream router's input port with the transmit_req/transmit_ack handshake and streams the buffered flits onto the link, one per cycle. It is the sending end of the inter-router link protocol.

## Interface
- DEPTH, NUM_OF_FLITS: buffer depth in flits; maximum packet length; power of two, at least 2.
- FLIT_W, FLIT_SIZE: flit width. MSB is the flit-valid bit.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: reset, asynchronous, active-low.
- i_flit  in  FLIT_t: flit from the switch stage. `i_flit.tail.flit_type` identifies TAIL_FLIT.
- i_flit_valid  in  1: switch presents a flit this cycle.
- o_switch_ready  out  1: the block accepts a flit this cycle.
- o_flit  out  FLIT_t: flit on the link. Registered. All-zero when idle.
- o_transmit_req  out  1: request to the downstream input port. Registered.
- i_transmit_ack  in  1: grant from downstream, sampled on clk.
- o_port_status  out  PORT_STATUS_t: PORT_OCCUPIED from the first accepted flit until the packet has been sent; PORT_FREE otherwise.
- o_pkt_sent  out  1: one-cycle pulse after the last flit leaves.
- o_len_err  out  1: sticky. Set when the buffer fills without a tail flit. Cleared only by reset.

## Operation
- A write occurs when i_flit_valid && o_switch_ready && i_flit[FLIT_W-1].
  - A flit whose MSB is 0 is ignored and causes no state change.
- o_switch_ready = (state is IDLE or FILL) && !fifo_full.
- State machine, OUT_STATE_t:
  - IDLE: a write moves to FILL. If that written flit is a tail, move directly to REQ (single-flit packet).
  - FILL: a tail write moves to REQ. If the buffer becomes full with no tail written, set o_len_err and move to REQ; the buffered flits are sent as one packet.
  - REQ: o_transmit_req = 1. i_transmit_ack high at an edge moves to SEND; o_transmit_req is 0 from that edge.
  - SEND: each edge pops the FIFO head into o_flit. When the popped flit empties the FIFO, move to DONE.
  - DONE: o_flit <= 0, o_pkt_sent = 1, o_port_status <= PORT_FREE. Next state is IDLE.
- i_transmit_ack outside REQ is ignored.
- REQ has no timeout: o_transmit_req is held until ack.
- Reset, including mid-packet: state IDLE, FIFO flushed, o_flit = 0, o_transmit_req = 0, o_pkt_sent = 0, o_len_err = 0, o_port_status = PORT_FREE, o_switch_ready = 1 once reset is released.

## Timing
- Tail written at edge E0 → o_transmit_req high from E0 (same edge).
- Ack sampled high at edge E1:
  - o_transmit_req low from E1.
  - Flit k (k = 0..N-1) is on o_flit from edge E1+k.
  - o_flit = 0 and o_pkt_sent = 1 from E1+N.
  - IDLE from E1+N+1.
- Downstream raises its write enable together with ack, so every flit driven from E1 onward is captured. No idle cycles occur between flits.
- Minimum turnaround, tail write to next packet accept: N+2 cycles after ack.
- Zero-latency ack (ack high at the first edge after E0) must work.

## Structure
- Package router_pkg holds: FLIT_t, FLIT_SIZE, NUM_OF_FLITS, TAIL_FLIT, PORT_STATUS_t (PORT_FREE, PORT_OCCUPIED), and a new OUT_STATE_t enum (O_IDLE, O_FILL, O_REQ, O_SEND, O_DONE).
- Sub-module: the existing sfifo, first-word fall-through, instantiated as OUTPUT_BUFFER with width FLIT_SIZE and address bits $clog2(DEPTH).
- FSM and output registers stay in output_unit.

## Test plan
- 4-flit packet (3 body + tail, MSB = 1), ack at the first edge after req → flits on o_flit in consecutive cycles in input order, then o_flit = 0 and a one-cycle o_pkt_sent pulse.
- Same packet, ack delayed 5 cycles → o_transmit_req high for exactly 6 cycles, o_switch_ready low throughout, no flit leaves before ack.
- Single tail flit → IDLE→REQ directly; one flit sent; o_port_status toggles OCCUPIED→FREE.
- DEPTH = 8 with a 9-flit packet (tail last) → o_switch_ready low after 8 writes, o_len_err = 1, 8 flits sent, 9th flit accepted as the next packet.
- Flits with MSB = 0 interleaved with valid flits, plus a spurious ack in IDLE → only MSB = 1 flits are buffered and sent; no req.
- reset_n low during SEND (after 2 of 4 flits) → all outputs at reset values immediately; a fresh 2-flit packet afterwards is sent correctly with no stale flits.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: flit layout, port status and the output-port FSM encoding.
package router_pkg;

  localparam int FLIT_SIZE    = 16;
  localparam int NUM_OF_FLITS = 8;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } FLIT_TYPE_t;

  typedef struct packed {
    logic                   valid;
    FLIT_TYPE_t             flit_type;
    logic [FLIT_SIZE-4:0]   payload;
  } FLIT_FIELDS_t;

  typedef union packed {
    logic [FLIT_SIZE-1:0] raw;
    FLIT_FIELDS_t         tail;
  } FLIT_t;

  typedef enum logic {
    PORT_FREE     = 1'b0,
    PORT_OCCUPIED = 1'b1
  } PORT_STATUS_t;

  typedef enum logic [2:0] {
    O_IDLE,
    O_FILL,
    O_REQ,
    O_SEND,
    O_DONE
  } OUT_STATE_t;

  function automatic logic is_tail(input FLIT_t f);
    return f.tail.flit_type == TAIL_FLIT;
  endfunction

endpackage

// File: rtl/output_unit_if.sv
// Switch-side and link-side signals of one router output port.
interface output_unit_if;
  import router_pkg::*;

  FLIT_t        i_flit;
  logic         i_flit_valid;
  logic         o_switch_ready;
  FLIT_t        o_flit;
  logic         o_transmit_req;
  logic         i_transmit_ack;
  PORT_STATUS_t o_port_status;
  logic         o_pkt_sent;
  logic         o_len_err;

  modport slave (
    input  i_flit, i_flit_valid, i_transmit_ack,
    output o_switch_ready, o_flit, o_transmit_req, o_port_status, o_pkt_sent, o_len_err
  );

  modport master (
    output i_flit, i_flit_valid, i_transmit_ack,
    input  o_switch_ready, o_flit, o_transmit_req, o_port_status, o_pkt_sent, o_len_err
  );

endinterface

// File: rtl/sfifo.sv
// Synchronous first-word fall-through FIFO; dout always shows the head entry.
module sfifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_BITS:0]    count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wptr, rptr;
  logic [ADDR_BITS:0]    cnt;
  logic                  do_wr, do_rd;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/output_unit.sv
// Router output port: store-and-forward one packet, then request the link and stream it out.
module output_unit
  import router_pkg::*;
#(
  parameter int DEPTH = NUM_OF_FLITS
) (
  input  logic          clk,
  input  logic          reset_n,
  output_unit_if.slave  bus
);

  localparam int FLIT_W    = FLIT_SIZE;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam logic [ADDR_BITS:0] LAST_SLOT = (ADDR_BITS+1)'(DEPTH-1);

  OUT_STATE_t          state, next_state;
  FLIT_t               flit_in;
  logic                ready, wr, rd, fills, tail_in;
  logic                full, empty;
  logic [ADDR_BITS:0]  count;
  logic [FLIT_W-1:0]   head;

  FLIT_t               flit_q;
  logic                req_q, sent_q, len_err_q;
  PORT_STATUS_t        status_q;

  assign flit_in = bus.i_flit;
  assign tail_in = is_tail(flit_in);

  sfifo #(
    .DATA_WIDTH (FLIT_W),
    .ADDR_BITS  (ADDR_BITS)
  ) OUTPUT_BUFFER (
    .clk   (clk),
    .rst_n (reset_n),
    .wr    (wr),
    .rd    (rd),
    .din   (flit_in.raw),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= O_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      O_IDLE: if (wr) next_state = (tail_in || fills) ? O_REQ : O_FILL;
      O_FILL: if (wr && (tail_in || fills)) next_state = O_REQ;
      O_REQ:  if (bus.i_transmit_ack) next_state = O_SEND;
      O_SEND: if (empty) next_state = O_DONE;
      O_DONE: next_state = O_IDLE;
      default: next_state = O_IDLE;
    endcase
  end

  // Flits with a clear valid bit never reach the buffer.
  always_comb begin
    ready = ((state == O_IDLE) || (state == O_FILL)) && !full;
    wr    = bus.i_flit_valid && ready && flit_in.tail.valid;
    fills = wr && !tail_in && (count == LAST_SLOT);
    rd    = ((state == O_REQ) && bus.i_transmit_ack) || ((state == O_SEND) && !empty);
  end

  // The ack edge already pops the first flit, so the link sees no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit_q    <= '0;
      req_q     <= 1'b0;
      sent_q    <= 1'b0;
      len_err_q <= 1'b0;
      status_q  <= PORT_FREE;
    end else begin
      flit_q <= rd ? head : '0;
      req_q  <= (next_state == O_REQ);
      sent_q <= (state == O_SEND) && empty;
      if (fills) len_err_q <= 1'b1;
      if ((state == O_IDLE) && wr)          status_q <= PORT_OCCUPIED;
      else if ((state == O_SEND) && empty)  status_q <= PORT_FREE;
    end
  end

  assign bus.o_switch_ready = ready;
  assign bus.o_flit         = flit_q;
  assign bus.o_transmit_req = req_q;
  assign bus.o_pkt_sent     = sent_q;
  assign bus.o_len_err      = len_err_q;
  assign bus.o_port_status  = status_q;

endmodule

// File: tb/tb_output_unit.sv
// Bench for output_unit: randomized packets checked against a packet-splitting reference model.
module tb_output_unit;
  import router_pkg::*;

  localparam int D = 8;
  typedef logic [FLIT_SIZE-1:0] flit_v;
  typedef flit_v fq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  output_unit_if bus();
  output_unit #(.DEPTH(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_v mk(input bit v, input logic [1:0] t);
    flit_v f;
    f = {v, t, 13'($urandom)};
    return f;
  endfunction

  function automatic bit same_q(input fq_t a, input fq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: keep valid flits in order; a packet closes on a tail or when D flits are held.
  task automatic model(input fq_t in, output fq_t exp, output int npk, output bit lerr);
    int cur;
    cur = 0; exp = {}; npk = 0; lerr = 1'b0;
    foreach (in[i]) begin
      if (in[i][FLIT_SIZE-1]) begin
        exp.push_back(in[i]);
        cur++;
        if (in[i][FLIT_SIZE-2 -: 2] == 2'd2 || cur == D) begin
          npk++;
          if (in[i][FLIT_SIZE-2 -: 2] != 2'd2) lerr = 1'b1;
          cur = 0;
        end
      end
    end
  endtask

  task automatic write_flits(input fq_t in, output bit ok);
    int b;
    ok = 1'b1;
    foreach (in[i]) begin
      b = 0;
      bus.i_flit = in[i];
      bus.i_flit_valid = 1'b1;
      while (!bus.o_switch_ready && b < 100) begin step(); b++; end
      if (b >= 100) ok = 1'b0;
      step();
    end
    bus.i_flit_valid = 1'b0;
    bus.i_flit = '0;
  endtask

  // Called right after the tail edge: hold ack low dly cycles, ack once, then watch the link.
  task automatic collect(input int dly, output fq_t got, output int reqc, output int pulse_at,
                         output int first, output bit early, output bit rdy_hi);
    got = {}; reqc = 0; pulse_at = -1; first = -1; early = 1'b0; rdy_hi = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      if (i == dly) bus.i_transmit_ack = 1'b1;
      if (bus.o_transmit_req) reqc++;
      if (bus.o_flit.raw != '0) early = 1'b1;
      if (bus.o_switch_ready) rdy_hi = 1'b1;
      step();
    end
    bus.i_transmit_ack = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      if (bus.o_flit.raw != '0) begin
        if (first < 0) first = i;
        got.push_back(bus.o_flit.raw);
      end
      if (bus.o_pkt_sent && pulse_at < 0) pulse_at = i;
      else if (bus.o_pkt_sent) pulse_at = 99;
      if (bus.o_transmit_req) reqc++;
      step();
    end
  endtask

  task automatic test_reset();
    bus.i_flit = '0; bus.i_flit_valid = 1'b0; bus.i_transmit_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    tests++; if (bus.o_flit.raw !== '0) begin fails++; $display("FAIL reset_flit got=%h exp=0", bus.o_flit.raw); end
    tests++; if (bus.o_transmit_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", bus.o_transmit_req); end
    tests++; if (bus.o_pkt_sent !== 1'b0) begin fails++; $display("FAIL reset_sent got=%b exp=0", bus.o_pkt_sent); end
    tests++; if (bus.o_len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err got=%b exp=0", bus.o_len_err); end
    tests++; if (bus.o_port_status !== PORT_FREE) begin fails++; $display("FAIL reset_status got=%b exp=0", bus.o_port_status); end
    tests++; if (bus.o_switch_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.o_switch_ready); end
  endtask

  task automatic test_zero_latency_ack();
    fq_t pk, exp; int npk; bit lerr, ok;
    pk = {mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd2)};
    model(pk, exp, npk, lerr);
    write_flits(pk, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL zl_write_timeout got=%b exp=1", ok); end
    tests++; if (bus.o_transmit_req !== 1'b1) begin fails++; $display("FAIL zl_req_at_tail got=%b exp=1", bus.o_transmit_req); end
    tests++; if (bus.o_port_status !== PORT_OCCUPIED) begin fails++; $display("FAIL zl_status_busy got=%b exp=1", bus.o_port_status); end
    bus.i_transmit_ack = 1'b1;
    step();
    bus.i_transmit_ack = 1'b0;
    tests++; if (bus.o_transmit_req !== 1'b0) begin fails++; $display("FAIL zl_req_drop got=%b exp=0", bus.o_transmit_req); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      tests++; if (bus.o_flit.raw !== exp[k]) begin fails++; $display("FAIL zl_flit%0d got=%h exp=%h", k, bus.o_flit.raw, exp[k]); end
    end
    step();
    tests++; if (bus.o_flit.raw !== '0) begin fails++; $display("FAIL zl_flit_idle got=%h exp=0", bus.o_flit.raw); end
    tests++; if (bus.o_pkt_sent !== 1'b1) begin fails++; $display("FAIL zl_pkt_sent got=%b exp=1", bus.o_pkt_sent); end
    tests++; if (bus.o_port_status !== PORT_FREE) begin fails++; $display("FAIL zl_status_free got=%b exp=0", bus.o_port_status); end
    step();
    tests++; if (bus.o_pkt_sent !== 1'b0) begin fails++; $display("FAIL zl_pulse_len got=%b exp=0", bus.o_pkt_sent); end
    tests++; if (bus.o_switch_ready !== 1'b1) begin fails++; $display("FAIL zl_ready_idle got=%b exp=1", bus.o_switch_ready); end
  endtask

  task automatic test_delayed_ack();
    fq_t pk, exp, got; int npk, reqc, pat, first; bit lerr, ok, early, rdy;
    pk = {mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd2)};
    model(pk, exp, npk, lerr);
    write_flits(pk, ok);
    collect(5, got, reqc, pat, first, early, rdy);
    tests++; if (reqc !== 6) begin fails++; $display("FAIL dl_req_cycles got=%0d exp=6", reqc); end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL dl_early_flit got=%b exp=0", early); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL dl_ready_low got=%b exp=0", rdy); end
    tests++; if (!same_q(got, exp)) begin fails++; $display("FAIL dl_flits got_n=%0d exp_n=%0d", got.size(), exp.size()); end
    tests++; if (first !== 0 || pat !== exp.size()) begin fails++; $display("FAIL dl_timing got=%0d/%0d exp=0/%0d", first, pat, exp.size()); end
  endtask

  task automatic test_single_tail();
    fq_t pk, exp, got; int npk, reqc, pat, first; bit lerr, ok, early, rdy;
    pk = {mk(1, 2'd2)};
    model(pk, exp, npk, lerr);
    tests++; if (bus.o_port_status !== PORT_FREE) begin fails++; $display("FAIL st_status_pre got=%b exp=0", bus.o_port_status); end
    write_flits(pk, ok);
    tests++; if (bus.o_port_status !== PORT_OCCUPIED) begin fails++; $display("FAIL st_status_busy got=%b exp=1", bus.o_port_status); end
    tests++; if (bus.o_transmit_req !== 1'b1) begin fails++; $display("FAIL st_req_direct got=%b exp=1", bus.o_transmit_req); end
    collect(0, got, reqc, pat, first, early, rdy);
    tests++; if (!same_q(got, exp)) begin fails++; $display("FAIL st_flits got_n=%0d exp_n=%0d", got.size(), exp.size()); end
    tests++; if (pat !== 1) begin fails++; $display("FAIL st_pulse got=%0d exp=1", pat); end
    tests++; if (bus.o_port_status !== PORT_FREE) begin fails++; $display("FAIL st_status_free got=%b exp=0", bus.o_port_status); end
  endtask

  task automatic test_invalid_and_spurious_ack();
    fq_t pk, exp, got; int npk, reqc, pat, first; bit lerr, ok, early, rdy;
    bus.i_transmit_ack = 1'b1;
    repeat (3) step();
    bus.i_transmit_ack = 1'b0;
    tests++; if (bus.o_transmit_req !== 1'b0 || bus.o_port_status !== PORT_FREE) begin
      fails++; $display("FAIL ia_spurious_ack got=%b/%b exp=0/0", bus.o_transmit_req, bus.o_port_status); end
    pk = {};
    for (int i = 0; i < 5; i++) begin
      pk.push_back(mk(0, 2'($urandom_range(0, 3))));
      pk.push_back(mk(1, 2'd1));
    end
    pk.push_back(mk(0, 2'd2));
    pk.push_back(mk(1, 2'd2));
    model(pk, exp, npk, lerr);
    write_flits(pk, ok);
    collect(1, got, reqc, pat, first, early, rdy);
    tests++; if (!same_q(got, exp)) begin fails++; $display("FAIL ia_flits got_n=%0d exp_n=%0d", got.size(), exp.size()); end
    tests++; if (reqc !== 2 || pat !== exp.size()) begin fails++; $display("FAIL ia_req_pulse got=%0d/%0d exp=2/%0d", reqc, pat, exp.size()); end
  endtask

  task automatic test_back_to_back();
    fq_t pk, exp, got; int npk, reqc, pat, first, len, dly; bit lerr, ok, early, rdy;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(1, D);
      dly = $urandom_range(0, 3);
      pk = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) pk.push_back(mk(0, 2'($urandom_range(0, 3))));
        pk.push_back(mk(1, (i == len - 1) ? 2'd2 : 2'($urandom_range(0, 1))));
      end
      model(pk, exp, npk, lerr);
      write_flits(pk, ok);
      collect(dly, got, reqc, pat, first, early, rdy);
      tests++; if (!same_q(got, exp) || pat !== exp.size() || reqc !== dly + 1) begin
        fails++; $display("FAIL b2b_pkt%0d got_n=%0d pulse=%0d req=%0d exp_n=%0d req=%0d", n, got.size(), pat, reqc, exp.size(), dly + 1); end
    end
    tests++; if (bus.o_len_err !== lerr) begin fails++; $display("FAIL b2b_len_err got=%b exp=%b", bus.o_len_err, lerr); end
  endtask

  task automatic test_len_err();
    fq_t pk, exp, got, part, rest; int npk, reqc, pat, first; bit lerr, ok, early, rdy;
    pk = {};
    for (int i = 0; i < D; i++) pk.push_back(mk(1, 2'd1));
    pk.push_back(mk(1, 2'd2));
    model(pk, exp, npk, lerr);
    part = pk[0:D-1];
    rest = pk[D:D];
    write_flits(part, ok);
    tests++; if (bus.o_switch_ready !== 1'b0) begin fails++; $display("FAIL le_ready_full got=%b exp=0", bus.o_switch_ready); end
    tests++; if (bus.o_len_err !== lerr) begin fails++; $display("FAIL le_flag got=%b exp=%b", bus.o_len_err, lerr); end
    collect(0, got, reqc, pat, first, early, rdy);
    part = exp[0:D-1];
    tests++; if (!same_q(got, part)) begin fails++; $display("FAIL le_first_pkt got_n=%0d exp_n=%0d", got.size(), part.size()); end
    write_flits(rest, ok);
    tests++; if (bus.o_port_status !== PORT_OCCUPIED || bus.o_transmit_req !== 1'b1) begin
      fails++; $display("FAIL le_second_accept got=%b/%b exp=1/1", bus.o_port_status, bus.o_transmit_req); end
    collect(2, got, reqc, pat, first, early, rdy);
    part = exp[D:D];
    tests++; if (!same_q(got, part) || npk !== 2) begin fails++; $display("FAIL le_second_pkt got_n=%0d exp_n=%0d", got.size(), part.size()); end
    tests++; if (bus.o_len_err !== 1'b1) begin fails++; $display("FAIL le_sticky got=%b exp=1", bus.o_len_err); end
  endtask

  task automatic test_reset_mid_send();
    fq_t pk, exp, got; int npk, reqc, pat, first; bit lerr, ok, early, rdy;
    pk = {mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd1), mk(1, 2'd2)};
    write_flits(pk, ok);
    bus.i_transmit_ack = 1'b1;
    step();
    bus.i_transmit_ack = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    tests++; if (bus.o_flit.raw !== '0 || bus.o_transmit_req !== 1'b0 || bus.o_pkt_sent !== 1'b0) begin
      fails++; $display("FAIL rm_outputs got=%h/%b/%b exp=0/0/0", bus.o_flit.raw, bus.o_transmit_req, bus.o_pkt_sent); end
    tests++; if (bus.o_len_err !== 1'b0 || bus.o_port_status !== PORT_FREE) begin
      fails++; $display("FAIL rm_flags got=%b/%b exp=0/0", bus.o_len_err, bus.o_port_status); end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    tests++; if (bus.o_switch_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got=%b exp=1", bus.o_switch_ready); end
    pk = {mk(1, 2'd1), mk(1, 2'd2)};
    model(pk, exp, npk, lerr);
    write_flits(pk, ok);
    collect(0, got, reqc, pat, first, early, rdy);
    tests++; if (!same_q(got, exp) || pat !== 2) begin fails++; $display("FAIL rm_fresh_pkt got_n=%0d pulse=%0d exp_n=2 pulse=2", got.size(), pat); end
  endtask

  initial begin
    bus.i_flit = '0;
    bus.i_flit_valid = 1'b0;
    bus.i_transmit_ack = 1'b0;
    test_reset();
    test_zero_latency_ack();
    test_delayed_ack();
    test_single_tail();
    test_invalid_and_spurious_ack();
    test_back_to_back();
    test_len_err();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
